mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MBR bus.
- Services one read or write per request with a fixed, parameterised number of wait states.
- On completion it returns read data for the MBR load path and a one-cycle acknowledge.
- Sits between the datapath (MAR address, MBR store data, control-unit strobes) and a word-addressed 16-bit RAM array held inside the block.

Parameters:
- ADDR_W, 8, address width in words.
- DEPTH, 256, number of implemented words; must be ≤ 2^ADDR_W.
- WAIT_STATES, 1, extra cycles between request capture and response; 0–15 legal.
- WP_LIMIT, 16, with MEM_WP_EN defined: addresses below this are write-protected.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rd_req  input  1  read request; the control unit raises it for the MBR-load phase.
- wr_req  input  1  write request; the control unit raises it for the MBR-store phase.
- addr  input  ADDR_W  word address from MAR.
- wdata  input  16  store data from MBR.
- rdata  output  16  read data to MBR load input.
- ack  output  1  one-cycle completion pulse.
- err  output  1  error status of the completed transaction; valid while ack=1.
- busy  output  1  high while a transaction is in flight.

Behaviour:
- Reset: one clock, one reset, synchronous active-high.
  - rst sampled high at a clk edge forces state=IDLE and rdata=0, ack=0, err=0, busy=0.
  - Wait counter is cleared; RAM contents are NOT cleared.
  - Reset mid-transaction aborts it: no write is performed and no ack is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - At edge T0 with exactly one of rd_req/wr_req high, latch addr, wdata and op; set busy=1.
  - Go to WAIT with counter=WAIT_STATES-1; if WAIT_STATES=0, go directly to RESP.
- WAIT: counter decrements each edge; at counter=0, go to RESP.
- RESP (one cycle). On the leaving edge:
  - ack=1, busy=0, state=IDLE.
  - Read: rdata=mem[latched addr].
  - Write: mem[latched addr]=latched wdata.
- Timing: ack is visible from edge T0+1+WAIT_STATES and for exactly one cycle. busy is high for cycles T0+1 … T0+WAIT_STATES+1, deasserting as ack rises.
- Back-to-back: a new request can be captured on the edge after the ack edge, so the throughput is one transaction per WAIT_STATES+2 cycles.
- Requests while busy=1 are ignored, not queued. The control unit holds or re-issues them.
- rd_req and wr_req both high in IDLE:
  - Captured as an illegal op; normal latency applies.
  - Completes with ack=1, err=1; no RAM write; rdata unchanged.
- Latched addr ≥ DEPTH:
  - Read: ack=1, err=1, rdata=0.
  - Write: ack=1, err=1, RAM unchanged.
- err is updated only on the ack edge. It is cleared to 0 on the next edge (it follows ack).
- rdata holds its value until the next successful or out-of-range read completes. Writes do not alter rdata.
- Input changes on addr/wdata after T0 have no effect on the in-flight transaction.

Optional Feature:
- Macro: MEM_WP_EN.
- Defined:
  - Writes with latched addr < WP_LIMIT complete with ack=1, err=1 and leave RAM unchanged.
  - Reads in that region are unaffected.
- Undefined: no protection; WP_LIMIT is unused; all in-range writes succeed.

Test Plan:
- Reset then write (WAIT_STATES=1): after rst, write addr=0x20, wdata=0xBEEF at T0. Required: busy high for 2 cycles, ack at T0+2 with err=0, then read addr=0x20 returns rdata=0xBEEF at ack.
- Latency sweep, WAIT_STATES=0 and 3: read is acknowledged at T0+1 and T0+4 respectively; ack is exactly one cycle wide; busy falls on the ack edge.
- Busy ignore: issue read 0x10, then pulse wr_req addr=0x10, wdata=0x1234 while busy. Required: only one ack; mem[0x10] unchanged on re-read.
- Errors: rd_req and wr_req both high → err=1, no write. Read addr=0xFF with DEPTH=200 → ack, err=1, rdata=0x0000.
- Reset mid-op: assert rst during WAIT of a write of 0xAAAA to 0x30. Required: no ack; outputs 0; a later read of 0x30 returns the prior contents.
- MEM_WP_EN (WP_LIMIT=16):
  - Write 0x5555 to 0x05 → err=1, and a later read of 0x05 returns the old value.
  - Write 0x5555 to 0x10 → err=0, and a later read returns 0x5555.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_responder                                                |
// | Description : MAR/MBR memory responder with fixed wait states, one-cycle   |
// |               ack and error status. Define MEM_WP_EN to write-protect the  |
// |               words below WP_LIMIT.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned WP_LIMIT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [1:0] c_OP_READ    = 2'd0;
    localparam logic [1:0] c_OP_WRITE   = 2'd1;
    localparam logic [1:0] c_OP_ILLEGAL = 2'd2;

    localparam int unsigned c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef MEM_WP_EN
    localparam logic c_WP_ON = 1'b1;
`else
    localparam logic c_WP_ON = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    logic [15:0]       r_mem [0:DEPTH-1];

    logic [31:0]        w_addr_ext;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_below_wp;
    logic               w_wp;
    logic               w_capture;
    logic [1:0]         w_new_op;
    logic               w_mem_we;
    logic [15:0]        w_rd_word;

    assign w_addr_ext = 32'(r_addr);
    assign w_idx      = r_addr[c_IDX_W-1:0];
    assign w_in_range = (w_addr_ext < DEPTH);
    // The limit compare is always built so the parameter stays referenced;
    // it folds away when protection is compiled out.
    assign w_below_wp = (w_addr_ext < WP_LIMIT);
    assign w_wp       = c_WP_ON & w_below_wp;

    assign w_capture = (r_state == c_ST_IDLE) && (rd_req || wr_req);
    assign w_new_op  = (rd_req && wr_req) ? c_OP_ILLEGAL :
                       rd_req             ? c_OP_READ    : c_OP_WRITE;

    // Reset in the response cycle must also suppress the RAM update.
    assign w_mem_we  = !rst && (r_state == c_ST_RESP) && (r_op == c_OP_WRITE)
                       && w_in_range && !w_wp;
    assign w_rd_word = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= c_OP_READ;
            r_addr  <= '0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_capture) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_op    <= w_new_op;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_WAIT_INIT;
                        r_state <= (WAIT_STATES == 0) ? c_ST_RESP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                    case (r_op)
                        c_OP_READ: begin
                            if (w_in_range) begin
                                r_rdata <= w_rd_word;
                                r_err   <= 1'b0;
                            end else begin
                                r_rdata <= 16'd0;
                                r_err   <= 1'b1;
                            end
                        end
                        c_OP_WRITE: r_err <= !w_in_range || w_wp;
                        default:    r_err <= 1'b1;
                    endcase
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_responder                                             |
// | Description : Directed bench for mem_responder: three instances cover      |
// |               WAIT_STATES 1 (DEPTH 200), 0 and 3.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_req [3];
    logic        wr_req [3];
    logic [7:0]  addr   [3];
    logic [15:0] wdata  [3];
    logic [15:0] rdata  [3];
    logic        ack    [3];
    logic        err    [3];
    logic        busy   [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DEPTH(200), .WAIT_STATES(1), .WP_LIMIT(16)) u_dut0 (
        .clk(clk), .rst(rst), .rd_req(rd_req[0]), .wr_req(wr_req[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
    );
    mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0), .WP_LIMIT(16)) u_dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req[1]), .wr_req(wr_req[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
    );
    mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3), .WP_LIMIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .rd_req(rd_req[2]), .wr_req(wr_req[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2])
    );

    // Issues one request and waits for its ack; lat is the number of edges from
    // the capture edge to the ack edge, or -1 if no ack arrives.
    task automatic run_op(input int d, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [15:0] wd,
                          output int lat, output int busy_cyc,
                          output logic [15:0] rv, output logic ev);
        @(negedge clk);
        rd_req[d] = rd; wr_req[d] = wr; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        rd_req[d] = 1'b0; wr_req[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd;
        lat = -1; busy_cyc = 0; rv = 16'hxxxx; ev = 1'bx;
        for (int j = 0; j <= 20; j++) begin
            if (busy[d] === 1'b1) busy_cyc++;
            if (ack[d] === 1'b1) begin
                lat = j; rv = rdata[d]; ev = err[d];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({rdata[d], ack[d], err[d], busy[d]} !== 19'd0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got rdata=%h ack=%b err=%b busy=%b want all 0",
                         d, rdata[d], ack[d], err[d], busy[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, bc; logic [15:0] rv; logic ev;
        run_op(0, 1'b0, 1'b1, 8'h20, 16'hBEEF, lat, bc, rv, ev);
        total++;
        if (lat !== 2 || bc !== 2 || ev !== 1'b0) begin
            bad++;
            $display("FAIL write_0x20: got lat=%0d busy=%0d err=%b want lat=2 busy=2 err=0", lat, bc, ev);
        end
        @(negedge clk);
        total++;
        if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin
            bad++;
            $display("FAIL ack_width_ws1: got ack=%b err=%b want 0 0", ack[0], err[0]);
        end
        run_op(0, 1'b1, 1'b0, 8'h20, 16'h0000, lat, bc, rv, ev);
        total++;
        if (lat !== 2 || rv !== 16'hBEEF || ev !== 1'b0) begin
            bad++;
            $display("FAIL read_0x20: got lat=%0d rdata=%h err=%b want 2 BEEF 0", lat, rv, ev);
        end
    endtask

    task automatic test_latency();
        int lat, bc; logic [15:0] rv; logic ev;
        run_op(1, 1'b0, 1'b1, 8'h40, 16'h1357, lat, bc, rv, ev);
        run_op(1, 1'b1, 1'b0, 8'h40, 16'h0000, lat, bc, rv, ev);
        total++;
        if (lat !== 1 || bc !== 1 || rv !== 16'h1357 || ev !== 1'b0) begin
            bad++;
            $display("FAIL latency_ws0: got lat=%0d busy=%0d rdata=%h err=%b want 1 1 1357 0", lat, bc, rv, ev);
        end
        @(negedge clk);
        total++;
        if (ack[1] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL ack_width_ws0: got ack=%b busy=%b want 0 0", ack[1], busy[1]);
        end
        run_op(2, 1'b0, 1'b1, 8'h47, 16'hC0DE, lat, bc, rv, ev);
        run_op(2, 1'b1, 1'b0, 8'h47, 16'h0000, lat, bc, rv, ev);
        total++;
        if (lat !== 4 || bc !== 4 || rv !== 16'hC0DE || ev !== 1'b0) begin
            bad++;
            $display("FAIL latency_ws3: got lat=%0d busy=%0d rdata=%h err=%b want 4 4 C0DE 0", lat, bc, rv, ev);
        end
        @(negedge clk);
        total++;
        if (ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL ack_width_ws3: got ack=%b busy=%b want 0 0", ack[2], busy[2]);
        end
    endtask

    // Holding rd_req high yields one transaction every WAIT_STATES+2 edges.
    task automatic test_back_to_back();
        int acks = 0;
        logic [15:0] last = 16'h0000;
        @(negedge clk);
        rd_req[0] = 1'b1; addr[0] = 8'h20;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (ack[0] === 1'b1) begin
                acks++;
                last = rdata[0];
            end
        end
        rd_req[0] = 1'b0;
        total++;
        if (acks !== 4 || last !== 16'hBEEF) begin
            bad++;
            $display("FAIL back_to_back: got acks=%0d rdata=%h want 4 BEEF", acks, last);
        end
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy[0]);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, acks; logic [15:0] rv, seen; logic ev;
        run_op(0, 1'b0, 1'b1, 8'h10, 16'h4321, lat, bc, rv, ev);
        acks = 0; seen = 16'h0000;
        @(negedge clk);
        rd_req[0] = 1'b1; addr[0] = 8'h10;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (ack[0] === 1'b1) begin
                acks++;
                seen = rdata[0];
            end
            if (j == 0) begin
                rd_req[0] = 1'b0; wr_req[0] = 1'b1; wdata[0] = 16'h1234;
            end else if (j == 1) begin
                wr_req[0] = 1'b0;
            end
        end
        total++;
        if (acks !== 1 || seen !== 16'h4321) begin
            bad++;
            $display("FAIL busy_ignore: got acks=%0d rdata=%h want 1 4321", acks, seen);
        end
        run_op(0, 1'b1, 1'b0, 8'h10, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'h4321 || ev !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_reread: got rdata=%h err=%b want 4321 0", rv, ev);
        end
    endtask

    task automatic test_errors();
        int lat, bc; logic [15:0] rv; logic ev;
        run_op(0, 1'b0, 1'b1, 8'h22, 16'h7777, lat, bc, rv, ev);
        run_op(0, 1'b1, 1'b0, 8'h22, 16'h0000, lat, bc, rv, ev);
        run_op(0, 1'b1, 1'b1, 8'h22, 16'h9999, lat, bc, rv, ev);
        total++;
        if (lat !== 2 || ev !== 1'b1 || rv !== 16'h7777) begin
            bad++;
            $display("FAIL illegal_op: got lat=%0d err=%b rdata=%h want 2 1 7777", lat, ev, rv);
        end
        @(negedge clk);
        total++;
        if (err[0] !== 1'b0 || ack[0] !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got err=%b ack=%b want 0 0", err[0], ack[0]);
        end
        run_op(0, 1'b1, 1'b0, 8'h22, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'h7777 || ev !== 1'b0) begin
            bad++;
            $display("FAIL illegal_no_write: got rdata=%h err=%b want 7777 0", rv, ev);
        end
        run_op(0, 1'b1, 1'b0, 8'hFF, 16'h0000, lat, bc, rv, ev);
        total++;
        if (lat !== 2 || ev !== 1'b1 || rv !== 16'h0000) begin
            bad++;
            $display("FAIL read_oor: got lat=%0d err=%b rdata=%h want 2 1 0000", lat, ev, rv);
        end
        run_op(0, 1'b0, 1'b1, 8'hC8, 16'h3333, lat, bc, rv, ev);
        total++;
        if (ev !== 1'b1 || rv !== 16'h0000) begin
            bad++;
            $display("FAIL write_oor_200: got err=%b rdata=%h want 1 0000", ev, rv);
        end
        run_op(0, 1'b0, 1'b1, 8'hC7, 16'hABCD, lat, bc, rv, ev);
        run_op(0, 1'b1, 1'b0, 8'hC7, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'hABCD || ev !== 1'b0) begin
            bad++;
            $display("FAIL last_word_199: got rdata=%h err=%b want ABCD 0", rv, ev);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, acks; logic [15:0] rv; logic ev;
        run_op(0, 1'b0, 1'b1, 8'h30, 16'h1111, lat, bc, rv, ev);
        run_op(0, 1'b1, 1'b0, 8'h30, 16'h0000, lat, bc, rv, ev);
        @(negedge clk);
        wr_req[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 16'hAAAA;
        @(negedge clk);
        wr_req[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({rdata[0], ack[0], err[0], busy[0]} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid_op_outputs: got rdata=%h ack=%b err=%b busy=%b want all 0",
                     rdata[0], ack[0], err[0], busy[0]);
        end
        acks = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (ack[0] === 1'b1) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL reset_mid_op_ack: got acks=%0d want 0", acks);
        end
        run_op(0, 1'b1, 1'b0, 8'h30, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'h1111 || ev !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_op_mem: got rdata=%h err=%b want 1111 0", rv, ev);
        end
    endtask

    task automatic test_write_protect();
        int lat, bc; logic [15:0] rv; logic ev;
        run_op(1, 1'b0, 1'b1, 8'h05, 16'h5555, lat, bc, rv, ev);
`ifdef MEM_WP_EN
        total++;
        if (ev !== 1'b1) begin
            bad++;
            $display("FAIL wp_write_0x05: got err=%b want 1", ev);
        end
        run_op(1, 1'b1, 1'b0, 8'h05, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv === 16'h5555 || ev !== 1'b0) begin
            bad++;
            $display("FAIL wp_read_0x05: got rdata=%h err=%b want old value (not 5555) 0", rv, ev);
        end
`else
        total++;
        if (ev !== 1'b0) begin
            bad++;
            $display("FAIL nowp_write_0x05: got err=%b want 0", ev);
        end
        run_op(1, 1'b1, 1'b0, 8'h05, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'h5555 || ev !== 1'b0) begin
            bad++;
            $display("FAIL nowp_read_0x05: got rdata=%h err=%b want 5555 0", rv, ev);
        end
`endif
        run_op(1, 1'b0, 1'b1, 8'h10, 16'h5555, lat, bc, rv, ev);
        total++;
        if (ev !== 1'b0) begin
            bad++;
            $display("FAIL wp_write_0x10: got err=%b want 0", ev);
        end
        run_op(1, 1'b1, 1'b0, 8'h10, 16'h0000, lat, bc, rv, ev);
        total++;
        if (rv !== 16'h5555 || ev !== 1'b0) begin
            bad++;
            $display("FAIL wp_read_0x10: got rdata=%h err=%b want 5555 0", rv, ev);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rd_req[d] = 1'b0; wr_req[d] = 1'b0; addr[d] = 8'h00; wdata[d] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_latency();
        test_back_to_back();
        test_busy_ignore();
        test_errors();
        test_reset_mid_op();
        test_write_protect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
